// File: rtl/data_mem_port.sv
// Handshaked byte-addressable data memory: lane steering, byte enables, load extension.
// Optional DATA_MEM_RANGE_CHECK_EN faults accesses outside the mapped window.
package data_mem_pkg;
   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;

   typedef struct packed {
      logic       write;
      addr_t      addr;
      logic [1:0] size;
      logic       uns;
      data_t      wdata;
   } mem_req_t;
endpackage

module data_mem_port
   import data_mem_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter addr_t       BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  addr_t       req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  data_t       req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output data_t       rsp_rdata,
   output logic        rsp_error
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   mem_req_t   req_q;
   data_t      rdata_q, rdata_d;
   logic       err_q, err_d;
   logic       accept, access;

   addr_t      offset;
   logic [IW-1:0] idx;
   logic [1:0] lane;
   logic       sz_byte, sz_half, sz_word;
   logic       misalign, out_of_range, fault;
   logic [3:0] be;
   data_t      wdata_sh, word_rd, word_sh, load_val;

   data_t      mem [DEPTH];

   assign offset  = req_q.addr - BASE_ADDR;
   assign idx     = offset[IW+1:2];
   assign lane    = req_q.addr[1:0];
   assign sz_byte = (req_q.size == 2'b00);
   assign sz_half = (req_q.size == 2'b01);
   assign sz_word = (req_q.size == 2'b10);

   always_comb begin
      misalign = 1'b1;
      unique case (1'b1)
         sz_byte: misalign = 1'b0;
         sz_half: misalign = lane[0];
         sz_word: misalign = (lane != 2'b00);
         default: misalign = 1'b1;
      endcase
   end

`ifdef DATA_MEM_RANGE_CHECK_EN
   // Offset wraps for addresses below BASE_ADDR, so one compare covers both ends.
   assign out_of_range = ({2'b00, offset[31:2]} >= 32'(DEPTH));
`else
   assign out_of_range = 1'b0;
`endif

   assign fault = misalign | out_of_range;

   always_comb begin
      be = 4'b1111;
      unique case (1'b1)
         sz_byte: be = 4'b0001 << lane;
         sz_half: be = lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   assign wdata_sh = req_q.wdata << {lane, 3'b000};
   assign word_rd  = mem[idx];
   assign word_sh  = word_rd >> {lane, 3'b000};

   always_comb begin
      load_val = word_rd;
      unique case (1'b1)
         sz_byte: load_val = req_q.uns ? {24'h0, word_sh[7:0]}
                                       : {{24{word_sh[7]}}, word_sh[7:0]};
         sz_half: load_val = req_q.uns ? {16'h0, word_sh[15:0]}
                                       : {{16{word_sh[15]}}, word_sh[15:0]};
         default: load_val = word_rd;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      accept    = 1'b0;
      access    = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               cnt_d   = 4'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = RESP;
               err_d   = fault;
               rdata_d = (fault || req_q.write) ? '0 : load_val;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            req_q <= '{write: req_write, addr: req_addr, size: req_size,
                       uns: req_unsigned, wdata: req_wdata};
         end
      end
   end

   // Array is deliberately not reset; commits only happen from WAIT.
   always_ff @(posedge clk) begin
      if (access && req_q.write && !fault) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_error = err_q;

   logic unused_bits;
   assign unused_bits = ^{offset[31:IW+2], offset[1:0], word_sh[31:16]};

endmodule
